// File: rtl/riscv_pkg.sv
// +--------------------------------------------------------------------+
// | riscv_pkg : shared RV32I datapath constants and control-bit types  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic       alusrc;
    logic [3:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alusrc:   1'b0,
    aluop:    ALU_ADD,
    memread:  1'b0,
    memwrite: 1'b0,
    regwrite: 1'b0,
    memtoreg: 1'b0,
    branch:   1'b0
  };

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// +--------------------------------------------------------------------+
// | hazard_detect : combinational load-use detector for ID/EX          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       lu
);

  logic w_ex_load;
  logic w_match1;
  logic w_match2;

  // x0 is hardwired zero, so a load targeting it never creates a dependence
  assign w_ex_load = ex_valid & ex_memread & (ex_rd != 5'd0);
  assign w_match1  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign w_match2  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign lu        = w_ex_load & id_valid & (w_match1 | w_match2);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// +--------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register, load-use stall, bubble count |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module id_ex_stage #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_data1,
  input  logic [XLEN-1:0]  id_data2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_alusrc,
  input  logic [3:0]       id_aluop,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             id_branch,
  input  logic             flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_data1,
  output logic [XLEN-1:0]  ex_data2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_alusrc,
  output logic [3:0]       ex_aluop,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_regwrite,
  output logic             ex_memtoreg,
  output logic             ex_branch,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  import riscv_pkg::*;

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_data1;
  logic [XLEN-1:0]  r_data2;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_cnt;

  ctrl_t            w_id_ctrl;
  logic             w_lu;
  logic             w_bubble;

  assign w_id_ctrl = '{
    alusrc:   id_alusrc,
    aluop:    id_aluop,
    memread:  id_memread,
    memwrite: id_memwrite,
    regwrite: id_regwrite,
    memtoreg: id_memtoreg,
    branch:   id_branch
  };

  hazard_detect u_hazard_detect (
    .ex_valid    (r_valid),
    .ex_memread  (r_ctrl.memread),
    .ex_rd       (r_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .lu          (w_lu)
  );

  // A flush already discards the decode instruction, so holding IF/ID is pointless
  assign stall    = w_lu & ~flush;
  assign w_bubble = flush | w_lu;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_ctrl  <= CTRL_NOP;
    end else begin
      r_valid <= id_valid;
      r_pc    <= id_pc;
      r_data1 <= id_data1;
      r_data2 <= id_data2;
      r_imm   <= id_imm;
      r_rs1   <= id_rs1;
      r_rs2   <= id_rs2;
      r_rd    <= id_rd;
      r_ctrl  <= w_id_ctrl;
    end
  end

  // Saturating count of inserted bubbles; empty-decode cycles are not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_bubble && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_data1    = r_data1;
  assign ex_data2    = r_data2;
  assign ex_imm      = r_imm;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_alusrc   = r_ctrl.alusrc;
  assign ex_aluop    = r_ctrl.aluop;
  assign ex_memread  = r_ctrl.memread;
  assign ex_memwrite = r_ctrl.memwrite;
  assign ex_regwrite = r_ctrl.regwrite;
  assign ex_memtoreg = r_ctrl.memtoreg;
  assign ex_branch   = r_ctrl.branch;
  assign bubble_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.
`default_nettype none

module tb_id_ex_stage;

  localparam int CW = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic        alusrc;
    logic [3:0]  aluop;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        mtr;
    logic        br;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        alusrc;
    logic [3:0]  aluop;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        mtr;
    logic        br;
  } ex_t;

  typedef struct {
    int            at;
    ex_t           ex;
    logic          stall;
    logic [CW-1:0] cnt;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  id_t  id;
  logic flush;

  logic          ex_valid, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch;
  logic [31:0]   ex_pc, ex_data1, ex_data2, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [3:0]    ex_aluop;
  logic          stall;
  logic [CW-1:0] bubble_cnt;
  ex_t           act;

  rec_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ex_t           pend_ex;
  logic [CW-1:0] pend_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  id_ex_stage #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id.valid), .id_pc(id.pc),
    .id_data1(id.d1), .id_data2(id.d2), .id_imm(id.imm),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_uses_rs1(id.u1), .id_uses_rs2(id.u2), .id_alusrc(id.alusrc),
    .id_aluop(id.aluop), .id_memread(id.mr), .id_memwrite(id.mw),
    .id_regwrite(id.rw), .id_memtoreg(id.mtr), .id_branch(id.br),
    .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data1(ex_data1), .ex_data2(ex_data2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  assign act = {ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_alusrc, ex_aluop, ex_memread, ex_memwrite, ex_regwrite,
                ex_memtoreg, ex_branch};

  function automatic ex_t to_ex(input id_t i);
    return {i.valid, i.pc, i.d1, i.d2, i.imm, i.rs1, i.rs2, i.rd,
            i.alusrc, i.aluop, i.mr, i.mw, i.rw, i.mtr, i.br};
  endfunction

  function automatic id_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic u1, input logic u2,
                             input logic mr, input logic mw);
    id_t i;
    i        = '0;
    i.valid  = 1'b1;
    i.pc     = pc;
    i.d1     = 32'h1000 + pc;
    i.d2     = 32'h2000 + pc;
    i.imm    = 32'h8;
    i.rs1    = rs1;
    i.rs2    = rs2;
    i.rd     = rd;
    i.u1     = u1;
    i.u2     = u2;
    i.mr     = mr;
    i.mw     = mw;
    i.rw     = ~mw;
    i.mtr    = mr;
    i.alusrc = mr | mw;
    i.aluop  = (mr | mw) ? 4'd0 : 4'd1;
    return i;
  endfunction

  // Monitor: compare every expectation scheduled for this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at == cyc) begin
      rec_t r;
      r = q.pop_front();
      checks = checks + 1;
      if (act !== r.ex) begin
        failures = failures + 1;
        $display("FAIL ex_fields cyc=%0d actual=%h expected=%h", cyc, act, r.ex);
      end
      checks = checks + 1;
      if (stall !== r.stall) begin
        failures = failures + 1;
        $display("FAIL stall cyc=%0d actual=%b expected=%b", cyc, stall, r.stall);
      end
      checks = checks + 1;
      if (bubble_cnt !== r.cnt) begin
        failures = failures + 1;
        $display("FAIL bubble_cnt cyc=%0d actual=%h expected=%h", cyc, bubble_cnt, r.cnt);
      end
    end
  end

  // Drive one cycle: check current EX state/counter plus this cycle's stall,
  // then record what the next edge should produce.
  task automatic step(input id_t i, input logic fl, input logic r, input logic exp_stall,
                      input ex_t nxt, input logic [CW-1:0] nxt_cnt);
    rec_t e;
    id    = i;
    flush = fl;
    rst   = r;
    e.at    = cyc;
    e.ex    = pend_ex;
    e.stall = exp_stall;
    e.cnt   = pend_cnt;
    q.push_back(e);
    pend_ex  = nxt;
    pend_cnt = nxt_cnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    id_t  a, l5, l0, d, i0, j, s, v0, idle;
    ex_t  bub;
    int   k;
    bub = '0;

    // Reset with random inputs for two edges
    rst   = 1'b1;
    id    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    flush = 1'($urandom);
    @(posedge clk);
    #1;
    id    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    rst      = 1'b0;
    pend_ex  = '0;
    pend_cnt = '0;

    a        = '0;
    a.valid  = 1'b1;
    a.pc     = 32'h100;
    a.d1     = 32'h0000_0005;
    a.d2     = 32'h0000_1234;
    a.imm    = 32'hFFFF_FFFC;
    a.rs1    = 5'd1;
    a.rs2    = 5'd2;
    a.rd     = 5'd7;
    a.u1     = 1'b1;
    a.alusrc = 1'b1;
    a.rw     = 1'b1;

    l5   = mk(32'h104, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    d    = mk(32'h108, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    l0   = mk(32'h10c, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    i0   = mk(32'h110, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    j    = mk(32'h118, 5'd4, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    s    = mk(32'h124, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    v0   = mk(32'h128, 5'd5, 5'd5, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    v0.valid = 1'b0;
    idle = '0;

    step(a,    1'b0, 1'b0, 1'b0, to_ex(a),  4'd0);   // pass-through
    step(l5,   1'b0, 1'b0, 1'b0, to_ex(l5), 4'd0);
    step(d,    1'b0, 1'b0, 1'b1, bub,       4'd1);   // load-use stall
    step(d,    1'b0, 1'b0, 1'b0, to_ex(d),  4'd1);   // held instr enters EX
    step(l0,   1'b0, 1'b0, 1'b0, to_ex(l0), 4'd1);
    step(i0,   1'b0, 1'b0, 1'b0, to_ex(i0), 4'd1);   // x0 load: no hazard
    step(l5,   1'b0, 1'b0, 1'b0, to_ex(l5), 4'd1);
    step(j,    1'b0, 1'b0, 1'b0, to_ex(j),  4'd1);   // rs2 match but unused
    step(l5,   1'b0, 1'b0, 1'b0, to_ex(l5), 4'd1);
    step(d,    1'b1, 1'b0, 1'b0, bub,       4'd2);   // flush beats load-use
    step(l5,   1'b0, 1'b0, 1'b0, to_ex(l5), 4'd2);
    step(s,    1'b0, 1'b0, 1'b1, bub,       4'd3);   // store data depends on load
    step(s,    1'b0, 1'b0, 1'b0, to_ex(s),  4'd3);
    step(v0,   1'b0, 1'b0, 1'b0, to_ex(v0), 4'd3);   // empty decode: not counted
    for (k = 1; k <= 20; k++) begin
      step(d, 1'b1, 1'b0, 1'b0, bub, (3 + k > 15) ? 4'hF : 4'(3 + k));
    end
    step(l5,   1'b0, 1'b0, 1'b0, to_ex(l5), 4'hF);
    step(d,    1'b0, 1'b1, 1'b1, bub,       4'd0);   // reset mid-stall
    step(d,    1'b0, 1'b0, 1'b0, to_ex(d),  4'd0);
    step(idle, 1'b0, 1'b0, 1'b0, bub,       4'd0);
    step(idle, 1'b0, 1'b0, 1'b0, bub,       4'd0);

    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    if (q.size() > 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage RV32I core. It captures decoded operands, the immediate and control bits from decode, and presents them registered to execute, where they feed the ALU operand muxes. It contains the load-use hazard detector: it drives the stall that holds PC and IF/ID, and it injects a one-cycle bubble into EX. It also honours branch flushes and keeps a saturating bubble counter for debug.

## Interface

Parameters:
- `XLEN`, 32: datapath width.
- `CNT_W`, 16: width of the bubble counter.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: decode holds a real instruction.
- `id_pc` in XLEN: PC of the decode instruction.
- `id_data1`, `id_data2` in XLEN: register-file read data.
- `id_imm` in XLEN: sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd` in 5: register indices.
- `id_uses_rs1`, `id_uses_rs2` in 1: the instruction actually reads rs1 / rs2.
- `id_alusrc` in 1: ALU operand-B select; 0 = data2, 1 = imm.
- `id_aluop` in 4: ALU operation code.
- `id_memread`, `id_memwrite`, `id_regwrite`, `id_memtoreg`, `id_branch` in 1: control bits.
- `flush` in 1: branch/jump taken in EX; squash the decode instruction.
- `ex_valid` out 1, plus `ex_pc`, `ex_data1`, `ex_data2`, `ex_imm`, `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_alusrc`, `ex_aluop`, `ex_memread`, `ex_memwrite`, `ex_regwrite`, `ex_memtoreg`, `ex_branch` out, same widths: registered copies.
- `stall` out 1: combinational; holds PC and IF/ID this cycle.
- `bubble_cnt` out CNT_W: number of bubbles inserted, saturating.

## Operation

- Load-use condition `lu`: `ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`.
- `stall = lu & ~flush`.
- Per-edge priority:
  - `rst`: all outputs 0.
  - Else `flush`: load a bubble.
  - Else `lu`: load a bubble.
  - Else: load all `id_*` into `ex_*` and set `ex_valid = id_valid`.
- Bubble contents:
  - `ex_valid`, `ex_memread`, `ex_memwrite`, `ex_regwrite`, `ex_branch` forced to 0.
  - `ex_aluop` = 0 (ADD).
  - `ex_rd` = 0.
  - Data fields and `ex_pc` are don't-care; the implementation loads 0.
- `bubble_cnt` increments by 1 on every bubble caused by `lu` or `flush`. It saturates at all-ones and does not wrap. Reset value is 0.
- Bubbles caused by `id_valid = 0` (no instruction in decode) are not counted.
- Register x0: `ex_rd == 0` never raises `lu`.
- A load with `id_uses_rs*` = 0 on the matching index does not raise `lu`; stores use rs2 as data and therefore do assert `id_uses_rs2`.

## Timing

- Latency: 1 cycle, decode to EX outputs.
- `stall` is same-cycle combinational from the current `ex_*` registers and the `id_*` inputs. It has no path from `bubble_cnt`.
- A load-use stall lasts exactly one cycle:
  - The bubble clears `ex_memread`, so `lu` deasserts the next cycle.
  - The held decode instruction then enters EX, where forwarding from MEM/WB covers the dependence.
- `flush` together with `lu`: flush wins. `stall` = 0, one bubble is inserted and counted once.
- Back-to-back flushes: a bubble every cycle, counted each cycle.
- Reset asserted mid-stall: the next edge clears everything. `stall` drops as soon as `ex_valid` = 0.
- Reset outputs: every `ex_*` = 0, `stall` = 0 (follows from `ex_valid` = 0), `bubble_cnt` = 0.

## Structure

- Shared package `riscv_pkg`:
  - `XLEN`.
  - ALU opcode constants, including `ALU_ADD = 4'd0`.
  - A packed struct `ctrl_t` {alusrc, aluop, memread, memwrite, regwrite, memtoreg, branch}, used for the control-bit fields.
  - Constant `CTRL_NOP` (all zero), used for bubbles.
- One sub-module, `hazard_detect`: purely combinational; computes `lu` from the EX and ID fields.
- The remainder of the stage is the pipeline register and the counter.

## Test plan

- Reset: hold `rst` for 2 cycles with random inputs → all `ex_*`, `stall` and `bubble_cnt` read 0.
- Pass-through:
  - Stimulus: `id_valid` = 1, `id_data1` = 0x0000_0005, `id_imm` = 0xFFFF_FFFC, `id_alusrc` = 1, `id_rd` = 7.
  - Response: next cycle `ex_*` carry the same values and `ex_valid` = 1.
- Load-use:
  - Cycle N: EX holds a load with `ex_rd` = 5.
  - Decode presents `id_rs1` = 5 with `id_uses_rs1` = 1.
  - Response: `stall` = 1 in N; bubble in EX at N+1; `bubble_cnt` = 1; `stall` = 0 at N+1; the instruction reaches EX at N+2.
- No false hazard:
  - Case 1: load to `ex_rd` = 0 with `id_rs1` = 0.
  - Case 2: load to rd = 5 with `id_rs2` = 5 and `id_uses_rs2` = 0.
  - Response in both cases: `stall` = 0 and no bubble.
- Flush priority: load-use condition and `flush` in the same cycle → `stall` = 0, one bubble, `bubble_cnt` increments by exactly 1.
- Saturation: with CNT_W = 4, apply 20 consecutive flushes → `bubble_cnt` sticks at 0xF.
